ble_pkt_loader: RTL and testbench
=================================

Name: ble_pkt_loader

Overview:
Parametrised successor to the hard-wired SPI-to-packet-memory loader. Parses the byte stream from spi_ctrl: load command, then length byte, then payload. Writes the payload into one of NUM_SLOTS packet buffers in the BLE packet RAM. Tracks which slots are full and hands completed packets to the transmit path through a commit/release handshake, with length checking, inter-byte timeout and abort.

Parameters:
DATA_W, 8, width of SPI byte and RAM data
SLOT_AW, 6, address bits per slot (slot capacity 2^SLOT_AW bytes)
SLOT_W, 1, slot index bits (NUM_SLOTS = 2^SLOT_W)
MAX_LEN, 39, largest legal payload length in bytes, must be <= 2^SLOT_AW
CMD_LOAD, 8'hAA, command byte that opens a packet load
TIMEOUT_CYC, 4096, clk cycles allowed between bytes inside a load (at least 2)

Ports:
clk  in  1  block clock (spi_ctrl clock domain)
rst_n  in  1  asynchronous active-low reset
rx_ready  in  1  one-cycle pulse, rx_data valid
rx_data  in  DATA_W  received SPI byte
abort  in  1  one-cycle pulse, cancel load in progress
slot_release  in  1  one-cycle pulse from TX path, frees release_slot
release_slot  in  SLOT_W  slot being freed
mem_we  out  1  RAM write enable, one-cycle pulse
mem_addr  out  SLOT_W+SLOT_AW  {slot, byte index}
mem_wdata  out  DATA_W  RAM write data
pkt_valid  out  1  one-cycle pulse, packet committed
pkt_slot  out  SLOT_W  slot of committed packet, held until next commit
pkt_len  out  8  length of committed packet, held until next commit
slot_full  out  2^SLOT_W  per-slot full flags
busy  out  1  high in LEN or DATA
err_nofree  out  1  pulse: LOAD received with all slots full
err_len  out  1  pulse: length 0 or > MAX_LEN
err_timeout  out  1  pulse: inter-byte timeout expired

Behaviour:
- Reset: all outputs 0. State IDLE. Counters 0. slot_full all 0.
- All outputs are registered. Inputs are sampled on the clk rising edge.
- IDLE:
  - rx_ready with rx_data==CMD_LOAD and a free slot: latch the lowest-indexed free slot as cur_slot, go to LEN.
  - No free slot: pulse err_nofree, stay IDLE.
  - Any other byte: ignored.
- LEN, on rx_ready:
  - rx_data==0 or rx_data>MAX_LEN: pulse err_len, go to IDLE, no RAM write.
  - Otherwise latch len=rx_data, idx=0, go to DATA.
- DATA, on each rx_ready:
  - Next cycle: mem_we=1, mem_addr={cur_slot,idx}, mem_wdata=rx_data. Latency is 1 cycle.
  - Then idx increments.
  - On the byte where idx==len-1, the same cycle as its mem_we: pkt_valid=1, pkt_slot=cur_slot, pkt_len=len, slot_full[cur_slot] set. Return to IDLE.
- Byte values inside DATA are never interpreted as commands (0xAA is payload).
- Timeout: counter clears on entry to LEN/DATA and on every rx_ready. When it reaches TIMEOUT_CYC-1 without a byte, pulse err_timeout and go to IDLE. Partial data stays in RAM, slot not marked full.
- abort in LEN/DATA: go to IDLE next cycle, no commit, no error pulse. An rx_ready in the same cycle is dropped. abort in IDLE is ignored.
- Reset mid-load: load discarded, all slots free.
- slot_release:
  - Clears slot_full[release_slot] next cycle.
  - Release of a non-full slot is ignored.
  - Release and commit in the same cycle on different slots both take effect.
  - Release of the slot currently loading cannot occur, because that slot is not full.
- Allocation at LOAD sees slot_full after any same-cycle release. The release has priority, so a slot freed in that cycle is allocatable.
- mem_addr/mem_wdata hold their last value when mem_we=0.

Test Plan:
- AA, 03, 11, 22, 33 into empty loader -> mem_we at addrs 0,1,2 with data 11,22,33; pkt_valid with the last write; pkt_slot=0, pkt_len=3, slot_full=01.
- Second AA, 02, 44, 55 -> writes at {1,0},{1,1} = addr 64,65; slot_full=11. Third AA -> err_nofree, busy stays 0. slot_release slot 0 plus AA in the same cycle -> slot 0 allocated.
- AA, 00 -> err_len, no mem_we. AA, 28 (40 > MAX_LEN) -> err_len. AA, 27 (39) -> 39 writes, commit.
- AA, 04, AA, AA, 01, 02 -> four writes of AA, AA, 01, 02; commit, no re-sync on payload AA.
- AA, 05, 2 bytes, then no rx_ready for TIMEOUT_CYC cycles -> err_timeout, IDLE, slot_full unchanged. Repeat with abort instead -> IDLE, no error pulse.
- rst_n low mid-payload, asynchronously between edges -> outputs 0 immediately, slot_full=0. Next AA allocates slot 0.

Source files
------------

// File: rtl/ble_pkt_loader.sv
// SPI byte stream -> BLE packet RAM loader: CMD_LOAD, length, payload into the lowest free slot.
// One-cycle write latency, commit pulses with the last write; no backpressure, every rx_ready byte is consumed.
module ble_pkt_loader #(
  parameter int                DATA_W      = 8,
  parameter int                SLOT_AW     = 6,
  parameter int                SLOT_W      = 1,
  parameter int                MAX_LEN     = 39,
  parameter logic [DATA_W-1:0] CMD_LOAD    = 8'hAA,
  parameter int                TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_ready,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      abort,
  input  logic                      slot_release,
  input  logic [SLOT_W-1:0]         release_slot,
  output logic                      mem_we,
  output logic [SLOT_W+SLOT_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      pkt_valid,
  output logic [SLOT_W-1:0]         pkt_slot,
  output logic [7:0]                pkt_len,
  output logic [(1<<SLOT_W)-1:0]    slot_full,
  output logic                      busy,
  output logic                      err_nofree,
  output logic                      err_len,
  output logic                      err_timeout
);

  localparam int NUM_SLOTS = 1 << SLOT_W;
  localparam int TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;

  state_t               state;
  logic [SLOT_W-1:0]    cur_slot;
  logic [7:0]           len;
  logic [SLOT_AW-1:0]   idx;
  logic [TW-1:0]        tmo;

  logic [NUM_SLOTS-1:0] rel_mask;
  logic [NUM_SLOTS-1:0] full_rel;
  logic [NUM_SLOTS-1:0] commit_mask;
  logic [SLOT_W-1:0]    alloc;
  logic                 any_free;
  logic                 is_last;
  logic                 commit;
  logic                 len_bad;
  logic                 tmo_hit;

  // Release is applied before allocation so a slot freed this cycle can be reused at once.
  always_comb begin
    rel_mask = '0;
    if (slot_release) rel_mask[release_slot] = 1'b1;
    full_rel = slot_full & ~rel_mask;
    any_free = ~&full_rel;
    alloc    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!full_rel[i]) alloc = SLOT_W'(i);
    end
    is_last     = (8'(idx) == len - 8'd1);
    commit      = (state == DATA) && rx_ready && !abort && is_last;
    commit_mask = '0;
    if (commit) commit_mask[cur_slot] = 1'b1;
    len_bad     = (rx_data == '0) || (rx_data > DATA_W'(MAX_LEN));
    tmo_hit     = (tmo == TMO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_slot    <= '0;
      len         <= '0;
      idx         <= '0;
      tmo         <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pkt_valid   <= 1'b0;
      pkt_slot    <= '0;
      pkt_len     <= '0;
      slot_full   <= '0;
      busy        <= 1'b0;
      err_nofree  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      mem_we      <= 1'b0;
      pkt_valid   <= 1'b0;
      err_nofree  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      slot_full   <= full_rel | commit_mask;

      case (state)
        IDLE: begin
          if (rx_ready && rx_data == CMD_LOAD) begin
            if (any_free) begin
              cur_slot <= alloc;
              tmo      <= '0;
              busy     <= 1'b1;
              state    <= LEN;
            end else begin
              err_nofree <= 1'b1;
            end
          end
        end

        LEN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (rx_ready) begin
            tmo <= '0;
            if (len_bad) begin
              err_len <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              len   <= 8'(rx_data);
              idx   <= '0;
              state <= DATA;
            end
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        DATA: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (rx_ready) begin
            tmo       <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= {cur_slot, idx};
            mem_wdata <= rx_data;
            idx       <= idx + SLOT_AW'(1);
            if (commit) begin
              pkt_valid <= 1'b1;
              pkt_slot  <= cur_slot;
              pkt_len   <= len;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end else if (tmo_hit) begin
            // Partial payload stays in RAM; the slot is simply not marked full.
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_pkt_loader.sv
// Scoreboard bench for ble_pkt_loader: expected RAM writes and commits queued as bytes are driven.
module tb_ble_pkt_loader;
  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       abort = 1'b0;
  logic       slot_release = 1'b0;
  logic [0:0] release_slot = 1'b0;

  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       pkt_valid;
  logic [0:0] pkt_slot;
  logic [7:0] pkt_len;
  logic [1:0] slot_full;
  logic       busy;
  logic       err_nofree;
  logic       err_len;
  logic       err_timeout;

  ble_pkt_loader #(
    .DATA_W(8), .SLOT_AW(6), .SLOT_W(1), .MAX_LEN(39),
    .CMD_LOAD(8'hAA), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .abort(abort), .slot_release(slot_release), .release_slot(release_slot),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pkt_valid(pkt_valid), .pkt_slot(pkt_slot), .pkt_len(pkt_len),
    .slot_full(slot_full), .busy(busy), .err_nofree(err_nofree),
    .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_nofree = 0;
  int n_len = 0;
  int n_tmo = 0;
  logic [14:0] wr_q[$];
  logic [8:0]  cm_q[$];
  logic [7:0]  pl[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wr_q.size() == 0) check_val("wr_q_size", wr_q.size(), 1);
        else begin
          logic [14:0] e;
          e = wr_q.pop_front();
          check_val("wr_addr", mem_addr, e[14:8]);
          check_val("wr_data", mem_wdata, e[7:0]);
        end
      end
      if (pkt_valid) begin
        check_val("commit_we", mem_we, 1);
        if (cm_q.size() == 0) check_val("cm_q_size", cm_q.size(), 1);
        else begin
          logic [8:0] c;
          c = cm_q.pop_front();
          check_val("pkt_slot", pkt_slot, c[8]);
          check_val("pkt_len", pkt_len, c[7:0]);
        end
      end
      if (err_nofree)  n_nofree++;
      if (err_len)     n_len++;
      if (err_timeout) n_tmo++;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rel(input logic s);
    slot_release = 1'b1;
    release_slot = s;
    @(posedge clk);
    #1;
    slot_release = 1'b0;
  endtask

  // Length byte then payload from pl; optionally release another slot alongside the final byte.
  task automatic load_body(input logic slot, input bit rel_last, input logic rel_s);
    send(8'(pl.size()));
    for (int i = 0; i < pl.size(); i++) begin
      wr_q.push_back({slot, 6'(i), pl[i]});
      if (i == pl.size() - 1) begin
        cm_q.push_back({slot, 8'(pl.size())});
        if (rel_last) begin
          slot_release = 1'b1;
          release_slot = rel_s;
        end
      end
      send(pl[i]);
      slot_release = 1'b0;
    end
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_pkt_valid", pkt_valid, 0);
    check_val("rst_pkt_len", pkt_len, 0);
    check_val("rst_full", slot_full, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_errs", {err_nofree, err_len, err_timeout}, 0);
    #5 rst_n = 1'b1;
    idle(1);

    pl = '{8'h11, 8'h22, 8'h33};
    send(8'hAA);
    check_val("busy_len", busy, 1);
    load_body(1'b0, 1'b0, 1'b0);
    check_val("full_a", slot_full, 2'b01);
    check_val("held_slot_a", pkt_slot, 0);
    check_val("held_len_a", pkt_len, 3);

    pl = '{8'h44, 8'h55};
    send(8'hAA);
    load_body(1'b1, 1'b0, 1'b0);
    check_val("full_b", slot_full, 2'b11);

    send(8'hAA);
    check_val("busy_nofree", busy, 0);
    idle(2);
    check_val("n_nofree", n_nofree, 1);

    // Release slot 0 in the same cycle as the load command.
    slot_release = 1'b1;
    release_slot = 1'b0;
    send(8'hAA);
    slot_release = 1'b0;
    check_val("busy_rel_alloc", busy, 1);
    pl = '{8'h66};
    load_body(1'b0, 1'b0, 1'b0);
    check_val("full_c", slot_full, 2'b11);

    rel(1'b0);
    idle(1);
    check_val("full_rel0", slot_full, 2'b10);
    pl = '{8'h77, 8'h88};
    send(8'hAA);
    load_body(1'b0, 1'b1, 1'b1);
    check_val("full_rel_commit", slot_full, 2'b01);
    rel(1'b0);
    idle(1);
    check_val("full_empty", slot_full, 2'b00);
    rel(1'b0);
    idle(1);
    check_val("full_rel_nonfull", slot_full, 2'b00);

    send(8'hAA); send(8'h00); idle(2);
    check_val("n_len_zero", n_len, 1);
    check_val("busy_len_zero", busy, 0);
    send(8'hAA); send(8'h28); idle(2);
    check_val("n_len_big", n_len, 2);
    pl = {};
    for (int i = 0; i < 39; i++) pl.push_back(8'(8'h30 + i));
    send(8'hAA);
    load_body(1'b0, 1'b0, 1'b0);
    check_val("full_max", slot_full, 2'b01);
    check_val("held_len_max", pkt_len, 39);

    pl = '{8'hAA, 8'hAA, 8'h01, 8'h02};
    send(8'hAA);
    load_body(1'b1, 1'b0, 1'b0);
    check_val("full_aa_payload", slot_full, 2'b11);
    check_val("held_slot_aa", pkt_slot, 1);
    rel(1'b0);
    rel(1'b1);
    idle(1);
    check_val("full_clear", slot_full, 2'b00);

    send(8'hAA); send(8'h05);
    wr_q.push_back({1'b0, 6'd0, 8'hC1}); send(8'hC1);
    wr_q.push_back({1'b0, 6'd1, 8'hC2}); send(8'hC2);
    idle(TMO - 2);
    check_val("tmo_early", n_tmo, 0);
    check_val("busy_before_tmo", busy, 1);
    idle(4);
    check_val("n_tmo", n_tmo, 1);
    check_val("busy_after_tmo", busy, 0);
    check_val("full_after_tmo", slot_full, 2'b00);

    send(8'hAA); send(8'h05);
    wr_q.push_back({1'b0, 6'd0, 8'hD1}); send(8'hD1);
    wr_q.push_back({1'b0, 6'd1, 8'hD2}); send(8'hD2);
    abort = 1'b1;
    send(8'hEE);
    abort = 1'b0;
    idle(2);
    check_val("busy_abort", busy, 0);
    check_val("full_abort", slot_full, 2'b00);
    check_val("errs_abort", n_nofree + n_len + n_tmo, 4);

    // Abort in IDLE must not suppress a command byte.
    abort = 1'b1;
    send(8'hAA);
    abort = 1'b0;
    check_val("busy_idle_abort", busy, 1);
    pl = '{8'h5A};
    load_body(1'b0, 1'b0, 1'b0);
    check_val("full_idle_abort", slot_full, 2'b01);

    send(8'hAA); send(8'h05);
    wr_q.push_back({1'b1, 6'd0, 8'hE1}); send(8'hE1);
    #6 rst_n = 1'b0;
    #1;
    check_val("mid_rst_full", slot_full, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_we", mem_we, 0);
    check_val("mid_rst_addr", mem_addr, 0);
    check_val("mid_rst_pkt_len", pkt_len, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    pl = '{8'h99};
    send(8'hAA);
    load_body(1'b0, 1'b0, 1'b0);
    check_val("post_rst_slot", pkt_slot, 0);
    check_val("post_rst_full", slot_full, 2'b01);

    idle(2);
    check_val("wr_q_drained", wr_q.size(), 0);
    check_val("cm_q_drained", cm_q.size(), 0);
    check_val("n_nofree_end", n_nofree, 1);
    check_val("n_len_end", n_len, 2);
    check_val("n_tmo_end", n_tmo, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
